// File: rtl/bullet_scan_ctrl.sv
// rtl/bullet_scan_ctrl.sv - per-frame bullet table scan with heart-box overlap detection
module bullet_scan_ctrl #(
    parameter int NUM_BULLETS = 16,
    parameter int PLAYER_SIZE = 8
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        frame_tick,
    input  logic [7:0]  player_x,
    input  logic [7:0]  player_y,
    output logic [3:0]  index,
    input  logic [15:0] bul_position,
    input  logic [15:0] bul_size,
    input  logic        bul_is_render,
    output logic        busy,
    output logic        done,
    output logic        hit,
    output logic [3:0]  hit_index,
    output logic [4:0]  live_count
);

    typedef enum logic [2:0] {
        IDLE  = 3'd0,
        SET   = 3'd1,
        WAIT  = 3'd2,
        CHECK = 3'd3,
        DONE  = 3'd4
    } state_t;

    localparam logic [3:0] LAST_INDEX = 4'(NUM_BULLETS - 1);
    localparam logic [8:0] PS         = 9'(PLAYER_SIZE);

    state_t      state;
    state_t      state_next;

    logic [7:0]  px;
    logic [7:0]  py;
    logic [4:0]  acc_live;
    logic        acc_hit;
    logic [3:0]  acc_idx;

    logic [8:0]  bx;
    logic [8:0]  by;
    logic [8:0]  bw;
    logic [8:0]  bh;
    logic        overlap;
    logic        last_entry;
    logic [4:0]  live_sum;

    // Edges are widened to 9 bits so a box reaching past 255 does not wrap to a small value
    assign bx = {1'b0, bul_position[15:8]};
    assign by = {1'b0, bul_position[7:0]};
    assign bw = {1'b0, bul_size[15:8]};
    assign bh = {1'b0, bul_size[7:0]};

    // Strict compares make touching edges a miss; zero-sized boxes are excluded explicitly
    assign overlap = bul_is_render
                   && (bw != 9'd0) && (bh != 9'd0)
                   && (bx < ({1'b0, px} + PS))
                   && ({1'b0, px} < (bx + bw))
                   && (by < ({1'b0, py} + PS))
                   && ({1'b0, py} < (by + bh));

    assign last_entry = (index == LAST_INDEX);
    assign live_sum   = acc_live + {4'd0, bul_is_render};

    // State register
    always_ff @(posedge clk) begin
        if (reset) begin
            state <= IDLE;
        end else begin
            state <= state_next;
        end
    end

    // Next-state and status outputs
    always_comb begin
        state_next = state;
        busy       = 1'b1;
        done       = 1'b0;
        hit        = 1'b0;
        case (state)
            IDLE: begin
                busy = 1'b0;
                if (frame_tick) begin
                    state_next = SET;
                end
            end
            SET:   state_next = WAIT;
            WAIT:  state_next = CHECK;
            CHECK: state_next = last_entry ? DONE : SET;
            DONE: begin
                done       = 1'b1;
                hit        = acc_hit;
                state_next = IDLE;
            end
            default: begin
                busy       = 1'b0;
                state_next = IDLE;
            end
        endcase
    end

    // Scan datapath: player latch, entry index, accumulators and held results
    always_ff @(posedge clk) begin
        if (reset) begin
            index      <= 4'd0;
            px         <= 8'd0;
            py         <= 8'd0;
            acc_live   <= 5'd0;
            acc_hit    <= 1'b0;
            acc_idx    <= 4'd0;
            hit_index  <= 4'd0;
            live_count <= 5'd0;
        end else begin
            case (state)
                IDLE: begin
                    if (frame_tick) begin
                        px       <= player_x;
                        py       <= player_y;
                        acc_live <= 5'd0;
                        acc_hit  <= 1'b0;
                        acc_idx  <= 4'd0;
                        index    <= 4'd0;
                    end
                end
                CHECK: begin
                    acc_live <= live_sum;
                    if (overlap && !acc_hit) begin
                        acc_hit <= 1'b1;
                        acc_idx <= index;
                    end
                    if (last_entry) begin
                        // Results land on the same edge as DONE so they are valid alongside done
                        live_count <= live_sum;
                        if (acc_hit) begin
                            hit_index <= acc_idx;
                        end else if (overlap) begin
                            hit_index <= index;
                        end
                    end else begin
                        index <= index + 4'd1;
                    end
                end
                default: begin
                end
            endcase
        end
    end

endmodule

// File: doc/bullet_scan_ctrl.md
BULLET_SCAN_CTRL -- requirements
Module: bullet_scan_ctrl

Interface
REQ-001 The block SHALL have parameter NUM_BULLETS, default 16, meaning the number of Bullet table entries scanned per frame (2..16).
REQ-002 The block SHALL have parameter PLAYER_SIZE, default 8, meaning the player heart box edge length in pixels (1..255).
REQ-003 The block SHALL have port clk  input  1  system clock; all logic is clocked on its rising edge.
REQ-004 The block SHALL have port reset  input  1  synchronous reset, active-high.
REQ-005 The block SHALL have port frame_tick  input  1  single-cycle scan request, one per video frame.
REQ-006 The block SHALL have port player_x  input  8  heart box left edge.
REQ-007 The block SHALL have port player_y  input  8  heart box top edge.
REQ-008 The block SHALL have port index  output  4  Bullet entry select, driven to the Bullet block.
REQ-009 The block SHALL have port bul_position  input  16  Bullet position, {x[15:8], y[7:0]}.
REQ-010 The block SHALL have port bul_size  input  16  Bullet size, {w[15:8], h[7:0]}.
REQ-011 The block SHALL have port bul_is_render  input  1  Bullet entry is live.
REQ-012 The block SHALL have port busy  output  1  high while a scan is in progress.
REQ-013 The block SHALL have port done  output  1  single-cycle pulse at scan end.
REQ-014 The block SHALL have port hit  output  1  single-cycle pulse, coincident with done, when any live bullet overlaps the heart.
REQ-015 The block SHALL have port hit_index  output  4  lowest overlapping index; valid when hit=1, held until the next done.
REQ-016 The block SHALL have port live_count  output  5  number of live entries from the last completed scan, held between scans.

Function
REQ-017 The FSM SHALL have states IDLE, SET, WAIT, CHECK, DONE.
REQ-018 In IDLE with frame_tick=1, the block SHALL latch player_x/player_y, clear the scan accumulators, set index=0 and go to SET.
REQ-019 SET SHALL go to WAIT and WAIT SHALL go to CHECK unconditionally, with index held stable, so the Bullet block has one registered cycle of lookup latency.
REQ-020 In CHECK the block SHALL sample bul_* for the current index, then go to SET with index+1, or to DONE if index=NUM_BULLETS-1.
REQ-021 Each entry SHALL take exactly 3 cycles; frame_tick to done SHALL take 3*NUM_BULLETS+1 cycles (49 at default).
REQ-022 DONE SHALL assert done for one cycle, update live_count, hit and hit_index, and return to IDLE.
REQ-023 busy SHALL be 1 in SET, WAIT, CHECK and DONE, and 0 in IDLE.
REQ-024 frame_tick SHALL be ignored while busy=1; no request is queued.
REQ-025 An entry SHALL overlap the heart when bul_is_render=1 and bx<px+PS, px<bx+bw, by<py+PS and py<by+bh.
REQ-026 The overlap compares SHALL use 9-bit unsigned sums, so that edges at 255 do not wrap.
REQ-027 An entry with w=0 or h=0 SHALL never overlap.
REQ-028 Touching edges (bx = px+PS) SHALL NOT count as an overlap.
REQ-029 hit_index SHALL record only the first overlapping index in a scan; later overlaps SHALL NOT overwrite it.
REQ-030 live_count SHALL count entries with bul_is_render=1; it reaches 16 without overflow.
REQ-031 Player coordinates SHALL be the values latched at scan start; player_x/player_y changes mid-scan SHALL have no effect.
REQ-032 Outside a scan, index SHALL hold its last value.

Reset
REQ-033 reset=1 at a clock edge SHALL force IDLE, index=0, busy=0, done=0, hit=0, hit_index=0 and live_count=0.
REQ-034 Reset mid-scan SHALL abort the scan with no done pulse and no update to the held outputs.
REQ-035 When reset and frame_tick are both high, reset SHALL win.
REQ-036 The first cycle after reset SHALL accept frame_tick.

Verification
REQ-037 Scenario: entries 0..15 all not live, frame_tick -> done at cycle 49, hit=0, live_count=0, index steps 0..15 every 3 cycles.
REQ-038 Scenario: heart (100,100), entry 5 live at (104,102) size 4x4, entry 9 overlapping, rest not live -> hit=1, hit_index=5, live_count=2.
REQ-039 Scenario: heart (100,100), entry 3 at (108,100) size 8x8 (touching edge) -> hit=0, live_count=1.
REQ-040 Scenario: heart (250,250), entry at (252,252) size 10x10 -> hit=1 (no wrap); entry at (0,0) size 255x2 -> no hit.
REQ-041 Scenario: frame_tick re-pulsed at cycles 10 and 30 -> ignored, single done at 49; player_x changed at cycle 20 -> no effect on the result.
REQ-042 Scenario: reset at cycle 20 of a scan -> busy=0 next cycle, no done, live_count keeps its prior value of 0; a new frame_tick completes normally.
